rgmii_rx_decoder: RTL and testbench

RGMII_RX_DECODER -- requirements
Module: rgmii_rx_decoder

---
 rtl/rgmii_rx_decoder_pkg.sv | 39 +++
 rtl/rgmii_rx_decoder_if.sv | 10 +
 rtl/rgmii_iddr_capture.sv | 44 ++++
 rtl/rgmii_rx_decoder.sv | 155 +++++++++++++++
 tb/tb_rgmii_rx_decoder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/rgmii_rx_decoder_pkg.sv
// rtl/rgmii_rx_decoder_pkg.sv - shared FSM encodings, Ethernet constants and in-band status decode
package rgmii_rx_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_t;

  localparam logic [7:0] ETH_PRE = 8'h55;
  localparam logic [7:0] ETH_SFD = 8'hD5;
  localparam logic [2:0] MAX_PRE = 3'd7;

  localparam logic [1:0] SPEED_10M   = 2'b00;
  localparam logic [1:0] SPEED_100M  = 2'b01;
  localparam logic [1:0] SPEED_1000M = 2'b10;

  typedef struct packed {
    logic       up;
    logic [1:0] speed;
    logic       duplex;
  } link_status_t;

  // Inter-frame rise nibble: bit0 link, bits 2:1 speed, bit3 duplex; code 11 passes through as-is.
  function automatic link_status_t decode_status(input logic [3:0] nib);
    link_status_t s;
    s.up     = nib[0];
    s.duplex = nib[3];
    case (nib[2:1])
      SPEED_10M:   s.speed = SPEED_10M;
      SPEED_100M:  s.speed = SPEED_100M;
      SPEED_1000M: s.speed = SPEED_1000M;
      default:     s.speed = nib[2:1];
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rgmii_rx_decoder_if.sv
// rtl/rgmii_rx_decoder_if.sv - unstallable received-byte stream
interface rgmii_rx_decoder_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser);
  modport slave  (input tdata, input tvalid, input tlast, input tuser);
endinterface

// File: rtl/rgmii_iddr_capture.sv
// rtl/rgmii_iddr_capture.sv - dual-edge input capture, both halves realigned to posedge
module rgmii_iddr_capture #(
  parameter string TARGET = "GENERIC",
  parameter int    WIDTH  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise_q,
  output logic [WIDTH-1:0] fall_q
);

  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] fall_r;

  always_ff @(posedge clk) begin
    if (!rst_n) rise_r <= '0;
    else        rise_r <= din;
  end

  // rst_n only moves just after a posedge, so the negedge flop sees the same level as the
  // following posedge; gating it or not is invisible once fall_q is re-registered.
  generate
    if (TARGET == "SIM") begin : g_sim
      always_ff @(negedge clk) fall_r <= din;
    end else begin : g_generic
      always_ff @(negedge clk) begin
        if (!rst_n) fall_r <= '0;
        else        fall_r <= din;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_r;
      fall_q <= fall_r;
    end
  end

endmodule

// File: rtl/rgmii_rx_decoder.sv
// rtl/rgmii_rx_decoder.sv - 1000M RGMII receive: preamble/SFD framing, byte stream, in-band status
module rgmii_rx_decoder
  import rgmii_rx_decoder_pkg::*;
#(
  parameter string TARGET         = "GENERIC",
  parameter bit    STRIP_PREAMBLE = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 rgmii_rxd,
  input  logic                       rgmii_rx_ctl,
  rgmii_rx_decoder_if.master         m_axis,
  output logic                       link_up,
  output logic [1:0]                 link_speed,
  output logic                       full_duplex,
  output logic                       bad_frame
);

  localparam bit KEEP_PRE = !STRIP_PREAMBLE;

  logic [4:0]   rise_q;
  logic [4:0]   fall_q;
  logic [7:0]   rx_byte;
  logic         rx_dv;
  logic         rx_er;
  rx_state_t    state;
  logic [2:0]   pre_cnt;
  logic [7:0]   buf_data;
  logic         buf_valid;
  logic         err_flag;
  link_status_t status_nxt;

  rgmii_iddr_capture #(.TARGET(TARGET), .WIDTH(5)) u_cap (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    ({rgmii_rx_ctl, rgmii_rxd}),
    .rise_q (rise_q),
    .fall_q (fall_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_byte <= '0;
      rx_dv   <= 1'b0;
      rx_er   <= 1'b0;
    end else begin
      rx_byte <= {fall_q[3:0], rise_q[3:0]};
      rx_dv   <= rise_q[4];
      rx_er   <= rise_q[4] ^ fall_q[4];
    end
  end

  assign status_nxt = decode_status(rx_byte[3:0]);

  // One-byte buffer: a byte leaves only when its successor (or end of dv) shows up, so the last
  // byte can be tagged tlast without lookahead.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      pre_cnt       <= '0;
      buf_data      <= '0;
      buf_valid     <= 1'b0;
      err_flag      <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      m_axis.tuser  <= 1'b0;
      link_up       <= 1'b0;
      link_speed    <= 2'b00;
      full_duplex   <= 1'b0;
      bad_frame     <= 1'b0;
    end else begin
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      m_axis.tuser  <= 1'b0;
      bad_frame     <= 1'b0;

      if (!rx_dv && !rx_er) begin
        link_up     <= status_nxt.up;
        link_speed  <= status_nxt.speed;
        full_duplex <= status_nxt.duplex;
      end

      case (state)
        ST_IDLE: begin
          if (rx_dv) begin
            if (rx_byte == ETH_PRE) begin
              state     <= ST_PREAMBLE;
              pre_cnt   <= 3'd1;
              buf_data  <= rx_byte;
              buf_valid <= KEEP_PRE;
              err_flag  <= 1'b0;
            end else begin
              state     <= ST_DROP;
              bad_frame <= 1'b1;
            end
          end
        end

        ST_PREAMBLE: begin
          if (!rx_dv) begin
            state     <= ST_IDLE;
            buf_valid <= 1'b0;
          end else if ((rx_byte == ETH_PRE && pre_cnt != MAX_PRE) || rx_byte == ETH_SFD) begin
            if (rx_byte == ETH_SFD) state <= ST_DATA;
            else                    pre_cnt <= pre_cnt + 3'd1;
            if (buf_valid) begin
              m_axis.tvalid <= 1'b1;
              m_axis.tdata  <= buf_data;
            end
            buf_data  <= rx_byte;
            buf_valid <= KEEP_PRE;
          end else begin
            state     <= ST_DROP;
            buf_valid <= 1'b0;
            bad_frame <= 1'b1;
          end
        end

        ST_DATA: begin
          if (rx_dv) begin
            if (buf_valid) begin
              m_axis.tvalid <= 1'b1;
              m_axis.tdata  <= buf_data;
            end
            buf_data  <= rx_byte;
            buf_valid <= 1'b1;
            if (rx_er) err_flag <= 1'b1;
          end else begin
            state     <= ST_IDLE;
            buf_valid <= 1'b0;
            err_flag  <= 1'b0;
            if (buf_valid) begin
              m_axis.tvalid <= 1'b1;
              m_axis.tdata  <= buf_data;
              m_axis.tlast  <= 1'b1;
              m_axis.tuser  <= err_flag;
              bad_frame     <= err_flag;
            end else begin
              bad_frame <= 1'b1;
            end
          end
        end

        ST_DROP: begin
          if (!rx_dv) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// tb/tb_rgmii_rx_decoder.sv - directed self-checking bench for rgmii_rx_decoder
module tb_rgmii_rx_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rxd;
  logic       ctl;

  logic       lu1, fd1, bad1, lu2, fd2, bad2;
  logic [1:0] ls1, ls2;

  rgmii_rx_decoder_if ax1 ();
  rgmii_rx_decoder_if ax2 ();

  rgmii_rx_decoder #(.TARGET("GENERIC"), .STRIP_PREAMBLE(1'b1)) dut_strip (
    .clk(clk), .rst_n(rst_n), .rgmii_rxd(rxd), .rgmii_rx_ctl(ctl), .m_axis(ax1),
    .link_up(lu1), .link_speed(ls1), .full_duplex(fd1), .bad_frame(bad1)
  );

  rgmii_rx_decoder #(.TARGET("SIM"), .STRIP_PREAMBLE(1'b0)) dut_keep (
    .clk(clk), .rst_n(rst_n), .rgmii_rxd(rxd), .rgmii_rx_ctl(ctl), .m_axis(ax2),
    .link_up(lu2), .link_speed(ls2), .full_duplex(fd2), .bad_frame(bad2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Beat record: {tlast, tuser, tdata}
  logic [9:0] q1[$];
  logic [9:0] q2[$];
  int c1[$];
  int nbad1 = 0, badcyc1 = -1, lastcyc1 = -2, dirty1 = 0, dirty2 = 0;

  always @(negedge clk) begin
    if (ax1.tvalid) begin
      q1.push_back({ax1.tlast, ax1.tuser, ax1.tdata});
      c1.push_back(cyc);
      if (ax1.tlast) lastcyc1 = cyc;
    end else if (ax1.tdata !== 8'h00 || ax1.tlast !== 1'b0 || ax1.tuser !== 1'b0) begin
      dirty1++;
    end
    if (ax2.tvalid) q2.push_back({ax2.tlast, ax2.tuser, ax2.tdata});
    else if (ax2.tdata !== 8'h00 || ax2.tlast !== 1'b0 || ax2.tuser !== 1'b0) dirty2++;
    if (bad1) begin
      nbad1++;
      badcyc1 = cyc;
    end
  end

  int errors = 0;
  int checks = 0;
  int last_cap = 0;
  int first_cap = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered just after a negedge; rise half captured at the next posedge.
  task automatic send(input logic [7:0] b, input bit dv, input bit er);
    rxd = b[3:0];
    ctl = dv;
    @(posedge clk);
    #2;
    last_cap = cyc;
    rxd = b[7:4];
    ctl = dv ^ er;
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input int n, input logic [7:0] b);
    for (int i = 0; i < n; i++) send(b, 1'b0, 1'b0);
  endtask

  task automatic frame(input int n, input int err_at, input int npre);
    for (int i = 0; i < npre; i++) send(8'h55, 1'b1, 1'b0);
    send(8'hD5, 1'b1, 1'b0);
    for (int k = 1; k <= n; k++) begin
      send(8'(k), 1'b1, k == err_at);
      if (k == 1) first_cap = last_cap;
    end
  endtask

  task automatic clear();
    q1.delete();
    q2.delete();
    c1.delete();
    nbad1 = 0;
    badcyc1 = -1;
    lastcyc1 = -2;
  endtask

  function automatic int count_last1();
    int n = 0;
    foreach (q1[i]) if (q1[i][9]) n++;
    return n;
  endfunction

  initial begin
    rst_n = 1'b0;
    rxd = 4'h0;
    ctl = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_tvalid", {31'd0, ax1.tvalid}, 32'd0);
    check("rst_tdata", {24'd0, ax1.tdata}, 32'd0);
    check("rst_tlast_tuser", {30'd0, ax1.tlast, ax1.tuser}, 32'd0);
    check("rst_status", {28'd0, lu1, ls1, fd1}, 32'd0);
    check("rst_bad", {30'd0, bad1, bad2}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    idle(4, 8'h00);

    // 60-byte frame, preamble stripped / kept
    clear();
    frame(60, 0, 7);
    idle(8, 8'h00);
    check("f36_beats", q1.size(), 60);
    for (int i = 0; i < 60 && i < q1.size(); i++) check("f36_data", {24'd0, q1[i][7:0]}, i + 1);
    check("f36_nlast", count_last1(), 1);
    check("f36_last_beat", {30'd0, q1[59][9:8]}, 32'b10);
    check("f36_latency", c1[0], first_cap + 4);
    check("f36_nbad", nbad1, 0);
    check("f36_keep_beats", q2.size(), 68);
    check("f36_keep_first", {24'd0, q2[0][7:0]}, 32'h55);
    check("f36_keep_sfd", {24'd0, q2[7][7:0]}, 32'hD5);
    check("f36_keep_pay", {24'd0, q2[8][7:0]}, 32'h01);

    // rx_er on byte 20
    clear();
    frame(60, 20, 7);
    idle(8, 8'h00);
    check("f37_beats", q1.size(), 60);
    check("f37_last_user", {30'd0, q1[59][9:8]}, 32'b11);
    check("f37_mid_user", {31'd0, q1[30][8]}, 32'd0);
    check("f37_nbad", nbad1, 1);
    check("f37_bad_at_last", badcyc1, lastcyc1);

    // Bad first byte
    clear();
    send(8'h12, 1'b1, 1'b0);
    send(8'h34, 1'b1, 1'b0);
    send(8'h56, 1'b1, 1'b0);
    send(8'h78, 1'b1, 1'b0);
    send(8'h9A, 1'b1, 1'b0);
    idle(8, 8'h00);
    check("f38_beats", q1.size(), 0);
    check("f38_nbad", nbad1, 1);
    clear();
    frame(4, 0, 7);
    idle(8, 8'h00);
    check("f38_recover_beats", q1.size(), 4);
    check("f38_recover_last", {22'd0, q1[3]}, {22'd0, 10'h204});

    // SFD then end of dv
    clear();
    frame(0, 0, 7);
    idle(8, 8'h00);
    check("sfd_end_beats", q1.size(), 0);
    check("sfd_end_nbad", nbad1, 1);

    // Eight preamble bytes
    clear();
    frame(4, 0, 8);
    idle(8, 8'h00);
    check("pre8_beats", q1.size(), 0);
    check("pre8_nbad", nbad1, 1);

    // In-band status, then false carrier
    clear();
    idle(8, 8'h0D);
    check("st_link", {28'd0, lu1, ls1, fd1}, 32'b1101);
    for (int i = 0; i < 8; i++) send(8'h0E, 1'b0, 1'b1);
    check("st_hold", {28'd0, lu1, ls1, fd1}, 32'b1101);
    check("st_keep_inst", {28'd0, lu2, ls2, fd2}, 32'b1101);
    check("st_no_out", q1.size() + nbad1, 0);

    // Reset pulse during byte 30
    clear();
    for (int i = 0; i < 7; i++) send(8'h55, 1'b1, 1'b0);
    send(8'hD5, 1'b1, 1'b0);
    for (int k = 1; k <= 60; k++) begin
      if (k == 30) begin
        rst_n = 1'b0;
        rxd = 4'hE;
        ctl = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        rxd = 4'h1;
        @(negedge clk);
        #2;
      end else begin
        send(8'(k), 1'b1, 1'b0);
      end
    end
    idle(8, 8'h00);
    check("f40_beats", q1.size(), 25);
    check("f40_nlast", count_last1(), 0);
    clear();
    frame(4, 0, 7);
    idle(8, 8'h00);
    check("f40_next_beats", q1.size(), 4);
    check("f40_next_last", count_last1(), 1);

    // Back-to-back frames, one idle cycle between
    clear();
    frame(60, 0, 7);
    idle(1, 8'h00);
    frame(60, 0, 7);
    idle(8, 8'h00);
    check("f41_keep_beats", q2.size(), 136);
    check("f41_keep_first", {22'd0, q2[0]}, 32'h055);
    check("f41_keep_tlast", {22'd0, q2[67]}, 32'h23C);
    check("f41_keep_second", {22'd0, q2[68]}, 32'h055);
    check("f41_strip_beats", q1.size(), 120);
    check("f41_strip_second", {22'd0, q1[60]}, 32'h001);
    check("f41_strip_nlast", count_last1(), 2);

    check("idle_zero_strip", dirty1, 0);
    check("idle_zero_keep", dirty2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
